// File: rtl/hs_mem_ctrl.sv
// Word memory slave with readM/inputReady handshake, READ_LAT wait-states and optional timer irq (HSMEM_TIMER_IRQ_EN).
// Read data after edge N+READ_LAT, held until readM drops; writes commit in one edge and are never stalled.
module hs_mem_ctrl #(
    parameter int    DATA_W     = 16,
    parameter int    ADDR_W     = 8,
    parameter int    DEPTH      = 256,
    parameter int    READ_LAT   = 0,
    parameter string INIT_FILE  = "",
    parameter int    IRQ_PERIOD = 50,
    parameter int    IRQ_PULSE  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              readM,
    input  logic              writeM,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              inputReady,
    output logic              err,
    output logic              irq,
    input  logic              irq_ack
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LP_LAT_M1 = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_wcnt;
    logic [3:0]          w_wcnt_nxt;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   w_raddr_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;
    logic                w_load;
    logic                w_close;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_rd_err;
    logic                w_wr_ok;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
    end

    // With zero latency the read is served on the accept edge, so the live address is used.
    assign w_rd_addr = (r_state == ST_IDLE) ? address : r_raddr;
    assign w_rd_idx  = w_rd_addr[IDX_W-1:0];
    assign w_rd_err  = ({1'b0, w_rd_addr} >= LP_DEPTH);
    assign w_wr_ok   = ({1'b0, address} < LP_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_raddr_nxt = r_raddr;
        w_load      = 1'b0;
        w_close     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (readM) begin
                    w_raddr_nxt = address;
                    if (READ_LAT == 0) begin
                        w_state_nxt = ST_READY;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_wcnt_nxt  = LP_LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (!readM) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = ST_READY;
                    w_load      = 1'b1;
                end else begin
                    w_wcnt_nxt  = r_wcnt - 4'd1;
                end
            end
            ST_READY: begin
                if (!readM) begin
                    w_state_nxt = ST_IDLE;
                    w_close     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
            r_raddr <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_raddr <= w_raddr_nxt;
            if (w_load) begin
                r_rdata <= w_rd_err ? '0 : r_mem[w_rd_idx];
                r_ready <= 1'b1;
                r_err   <= w_rd_err;
            end else if (w_close) begin
                r_rdata <= '0;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    // Memory is deliberately outside reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (writeM && w_wr_ok) r_mem[address[IDX_W-1:0]] <= wdata;
    end

    assign rdata      = r_rdata;
    assign inputReady = r_ready;
    assign err        = r_err;

`ifdef HSMEM_TIMER_IRQ_EN
    localparam int TC_W = $clog2(IRQ_PERIOD);
    localparam int PC_W = (IRQ_PULSE > 1) ? $clog2(IRQ_PULSE) : 1;

    logic [TC_W-1:0] r_tcnt;
    logic [PC_W-1:0] r_pcnt;
    logic            r_irq;

    // A period expiry wins over ack and pulse end, restarting the pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tcnt <= '0;
            r_pcnt <= '0;
            r_irq  <= 1'b0;
        end else if (r_tcnt == TC_W'(IRQ_PERIOD - 1)) begin
            r_tcnt <= '0;
            r_irq  <= 1'b1;
            r_pcnt <= PC_W'(IRQ_PULSE - 1);
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_irq) begin
                if (irq_ack || (r_pcnt == '0)) r_irq  <= 1'b0;
                else                           r_pcnt <= r_pcnt - 1'b1;
            end
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_ack;
    assign w_unused_irq_ack = irq_ack;
    assign irq              = 1'b0;
`endif

endmodule
